maze_round_ctrl: RTL and testbench

Round sequencer for the maze game's BCD score counter. It turns the raw start, move and goal signals into clean single-cycle controls for the score block: reset, move penalty, one-second tick and win freeze. It also detects loss when the score reaches zero and, optionally, keeps a best-score record. It sits between the maze/player logic and the score/display block.

---
 rtl/maze_round_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_maze_round_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_round_ctrl.sv
// maze_round_ctrl: round sequencer for the maze game's BCD score counter.
//
// Turns raw start / move / goal levels into clean one-cycle controls for the
// score block (reload, move penalty, one-second tick) plus a win-freeze level.
// It detects a loss when the fed-back score reaches 0000. When the macro
// BEST_SCORE_EN is defined it also keeps the best winning score since reset.
// Without that macro, best_bcd_o is tied to 0 and best_valid_o to 0.
//
// Parameters
//   TICK_DIV       clk cycles per score tick; must be >= 2
// Ports
//   clk            system clock
//   rst            synchronous, active-high reset
//   start_i        level; rising edge starts / restarts a round
//   move_req_i     level; each rising edge is one player move
//   goal_reached_i level; high while the player sits on the goal cell
//   score_bcd_i    current 4-digit BCD score from the score block
//   score_rst_o    one-cycle pulse: reload score to 9999
//   score_move_o   one-cycle pulse: move penalty
//   score_tick_o   one-cycle pulse: time decrement
//   score_win_o    level: freeze the score block (round won)
//   state_o        0=IDLE, 1=ARMED, 2=RUN, 3=DONE
//   won_o, lost_o  round outcome, valid while in DONE
//   best_bcd_o     best winning score since reset
//   best_valid_o   best_bcd_o holds a real score
module maze_round_ctrl #(
  parameter int unsigned TICK_DIV = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        move_req_i,
  input  logic        goal_reached_i,
  input  logic [15:0] score_bcd_i,
  output logic        score_rst_o,
  output logic        score_move_o,
  output logic        score_tick_o,
  output logic        score_win_o,
  output logic [1:0]  state_o,
  output logic        won_o,
  output logic        lost_o,
  output logic [15:0] best_bcd_o,
  output logic        best_valid_o
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic            score_rst_q, score_rst_d;
  logic            score_move_q, score_move_d;
  logic            score_tick_q, score_tick_d;
  logic            won_q, won_d;
  logic            lost_q, lost_d;

  // Input sample flops followed by prev flops. Both reset to 1 so a level that
  // is already high when reset releases is never seen as a rising edge.
  logic start_s_q, start_p_q;
  logic move_s_q, move_p_q;
  logic goal_s_q;

  logic start_edge, move_edge;

  assign start_edge = start_s_q & ~start_p_q;
  assign move_edge  = move_s_q & ~move_p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      start_s_q <= 1'b1;
      start_p_q <= 1'b1;
      move_s_q  <= 1'b1;
      move_p_q  <= 1'b1;
      goal_s_q  <= 1'b1;
    end else begin
      start_s_q <= start_i;
      start_p_q <= start_s_q;
      move_s_q  <= move_req_i;
      move_p_q  <= move_s_q;
      goal_s_q  <= goal_reached_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    score_rst_d  = 1'b0;
    score_move_d = 1'b0;
    score_tick_d = 1'b0;
    won_d        = won_q;
    lost_d       = lost_q;

    unique case (state_q)
      StIdle: begin
        if (start_edge) begin
          score_rst_d = 1'b1;
          state_d     = StArmed;
        end
      end

      StArmed: begin
        // A restart in the same cycle as the first move wins; the move is dropped.
        if (start_edge) begin
          score_rst_d = 1'b1;
        end else if (move_edge) begin
          score_move_d = 1'b1;
          state_d      = StRun;
        end
      end

      StRun: begin
        // The move penalty is charged even on the cycle the round ends.
        score_move_d = move_edge;
        if (goal_s_q) begin
          state_d = StDone;
          won_d   = 1'b1;
        end else if (score_bcd_i == 16'h0000) begin
          state_d = StDone;
          lost_d  = 1'b1;
        end else if (start_edge) begin
          score_rst_d = 1'b1;
          state_d     = StArmed;
        end else if (div_q == DivMax) begin
          score_tick_d = 1'b1;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end

      StDone: begin
        if (start_edge) begin
          score_rst_d = 1'b1;
          won_d       = 1'b0;
          lost_d      = 1'b0;
          state_d     = StArmed;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      div_q        <= '0;
      score_rst_q  <= 1'b0;
      score_move_q <= 1'b0;
      score_tick_q <= 1'b0;
      won_q        <= 1'b0;
      lost_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      score_rst_q  <= score_rst_d;
      score_move_q <= score_move_d;
      score_tick_q <= score_tick_d;
      won_q        <= won_d;
      lost_q       <= lost_d;
    end
  end

`ifdef BEST_SCORE_EN
  logic [15:0] best_q;
  logic        best_valid_q;
  logic        best_upd;

  // Valid BCD orders the same as plain unsigned binary, so a 16-bit compare works.
  assign best_upd = (state_q == StRun) && goal_s_q &&
                    (!best_valid_q || (score_bcd_i > best_q));

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q       <= 16'h0000;
      best_valid_q <= 1'b0;
    end else if (best_upd) begin
      best_q       <= score_bcd_i;
      best_valid_q <= 1'b1;
    end
  end

  assign best_bcd_o   = best_q;
  assign best_valid_o = best_valid_q;
`else
  assign best_bcd_o   = 16'h0000;
  assign best_valid_o = 1'b0;
`endif

  assign score_rst_o  = score_rst_q;
  assign score_move_o = score_move_q;
  assign score_tick_o = score_tick_q;
  assign score_win_o  = won_q;
  assign state_o      = state_q;
  assign won_o        = won_q;
  assign lost_o       = lost_q;

endmodule

// File: tb/tb_maze_round_ctrl.sv
// Testbench for maze_round_ctrl with TICK_DIV=4. A reference model tracks the
// round as a phase number, input history and "cycles spent in RUN" and is
// stepped once per clock; every output is compared after every edge. Directed
// scenarios come first, then a randomized phase.
module tb_maze_round_ctrl;

  localparam int unsigned TD = 4;

  logic        clk = 1'b0;
  logic        rst, start, move_req, goal;
  logic [15:0] score;
  logic        score_rst_o, score_move_o, score_tick_o, score_win_o;
  logic [1:0]  state_o;
  logic        won_o, lost_o, best_valid_o;
  logic [15:0] best_bcd_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  maze_round_ctrl #(.TICK_DIV(TD)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .move_req_i    (move_req),
    .goal_reached_i(goal),
    .score_bcd_i   (score),
    .score_rst_o   (score_rst_o),
    .score_move_o  (score_move_o),
    .score_tick_o  (score_tick_o),
    .score_win_o   (score_win_o),
    .state_o       (state_o),
    .won_o         (won_o),
    .lost_o        (lost_o),
    .best_bcd_o    (best_bcd_o),
    .best_valid_o  (best_valid_o)
  );

  // Reference model state
  int          m_phase;  // 0 idle, 1 armed, 2 run, 3 done
  int          m_age;    // clock edges spent in RUN since entry
  bit          m_rst, m_move, m_tick, m_won, m_lost, m_bvalid;
  logic [15:0] m_best;
  // Input values seen one and two edges ago
  bit          h1s, h1m, h1g, h2s, h2m;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit se, me, gl;
    if (rst) begin
      m_phase = 0; m_age = 0;
      m_rst = 0; m_move = 0; m_tick = 0; m_won = 0; m_lost = 0;
      m_bvalid = 0; m_best = 16'h0000;
      h1s = 1; h1m = 1; h1g = 1; h2s = 1; h2m = 1;
      return;
    end
    se = h1s && !h2s;
    me = h1m && !h2m;
    gl = h1g;
    m_rst = 0; m_move = 0; m_tick = 0;
    case (m_phase)
      0: if (se) begin m_rst = 1; m_phase = 1; end
      1: begin
        if (se) m_rst = 1;
        else if (me) begin m_move = 1; m_phase = 2; m_age = 0; end
      end
      2: begin
        m_move = me;
        if (gl) begin
          m_phase = 3; m_won = 1;
`ifdef BEST_SCORE_EN
          if (!m_bvalid || score > m_best) begin m_best = score; m_bvalid = 1; end
`endif
        end else if (score == 16'h0000) begin
          m_phase = 3; m_lost = 1;
        end else if (se) begin
          m_rst = 1; m_phase = 1;
        end else begin
          m_age++;
          m_tick = (m_age % TD) == 0;
        end
      end
      default: if (se) begin m_rst = 1; m_won = 0; m_lost = 0; m_phase = 1; end
    endcase
    h2s = h1s; h2m = h1m;
    h1s = start; h1m = move_req; h1g = goal;
  endtask

  task automatic compare_all();
    chk("state", 16'(state_o), 16'(m_phase));
    chk("score_rst", 16'(score_rst_o), 16'(m_rst));
    chk("score_move", 16'(score_move_o), 16'(m_move));
    chk("score_tick", 16'(score_tick_o), 16'(m_tick));
    chk("score_win", 16'(score_win_o), 16'(m_won));
    chk("won", 16'(won_o), 16'(m_won));
    chk("lost", 16'(lost_o), 16'(m_lost));
    chk("best_bcd", best_bcd_o, m_best);
    chk("best_valid", 16'(best_valid_o), 16'(m_bvalid));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input int want, input int lim);
    for (int i = 0; i < lim && int'(state_o) != want; i++) step();
    chk("wait_state", 16'(state_o), 16'(want));
  endtask

  task automatic pulse_start();
    start = 1; step(); step();
    start = 0; step();
  endtask

  task automatic enter_run();
    pulse_start();
    wait_state(1, 10);
    move_req = 1;
    wait_state(2, 10);
    move_req = 0;
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int d = 0; d < 4; d++) v[d*4 +: 4] = 4'($urandom % 10);
    return v;
  endfunction

  initial begin
    int n;
    rst = 1; start = 0; move_req = 0; goal = 0; score = 16'h9999;
    repeat (3) step();
    chk("reset_state", 16'(state_o), 16'd0);
    rst = 0;
    repeat (3) step();

    // Held start gives exactly one reload pulse
    start = 1;
    n = 0;
    repeat (52) begin step(); if (score_rst_o) n++; end
    chk("start_once", 16'(n), 16'd1);
    chk("armed", 16'(state_o), 16'd1);
    start = 0; step();

    // First move enters RUN; ticks at +4, +8, +12
    move_req = 1;
    wait_state(2, 10);
    n = 0;
    repeat (12) begin step(); if (score_tick_o) n++; end
    chk("tick_count", 16'(n), 16'd3);
    move_req = 0;

    // Win with 9871
    score = 16'h9871; goal = 1;
    wait_state(3, 10);
    chk("won_9871", 16'(won_o), 16'd1);
    chk("win_freeze", 16'(score_win_o), 16'd1);
`ifdef BEST_SCORE_EN
    chk("best_9871", best_bcd_o, 16'h9871);
    chk("best_valid_1", 16'(best_valid_o), 16'd1);
`else
    chk("best_off", best_bcd_o, 16'h0000);
    chk("best_valid_off", 16'(best_valid_o), 16'd0);
`endif
    goal = 0; step();

    // Lower winning score keeps the record
    score = 16'h9999;
    enter_run();
    score = 16'h9500; goal = 1;
    wait_state(3, 10);
    goal = 0; step();
`ifdef BEST_SCORE_EN
    chk("best_kept", best_bcd_o, 16'h9871);
`else
    chk("best_kept_off", best_bcd_o, 16'h0000);
`endif

    // Loss at zero; moves and ticks ignored in DONE
    score = 16'h9999;
    enter_run();
    score = 16'h0000;
    wait_state(3, 10);
    chk("lost", 16'(lost_o), 16'd1);
    chk("lost_no_freeze", 16'(score_win_o), 16'd0);
    n = 0;
    repeat (4) begin
      move_req = 1; step(); step(); if (score_move_o) n++;
      move_req = 0; step(); step(); if (score_move_o || score_tick_o) n++;
    end
    chk("done_quiet", 16'(n), 16'd0);

    // Goal and move edge together: move still charged, then frozen
    score = 16'h9999;
    enter_run();
    step(); step();
    goal = 1; move_req = 1;
    n = 0;
    repeat (6) begin step(); if (score_move_o) n++; end
    chk("goal_move_pulse", 16'(n), 16'd1);
    chk("goal_move_won", 16'(won_o), 16'd1);
    n = 0;
    repeat (8) begin step(); if (score_tick_o) n++; end
    chk("no_tick_done", 16'(n), 16'd0);
    goal = 0; move_req = 0; step();

    // Reset one cycle before the tick wrap
    enter_run();
    repeat (3) step();
    rst = 1; step();
    chk("rst_no_tick", 16'(score_tick_o), 16'd0);
    chk("rst_state", 16'(state_o), 16'd0);
    chk("rst_best", best_bcd_o, 16'h0000);
    rst = 0; step();

    // Randomized phase
    for (int c = 0; c < 2500; c++) begin
      if ($urandom % 30 == 0) start = ~start;
      if ($urandom % 4 == 0) move_req = ~move_req;
      goal = ($urandom % 20 == 0);
      if ($urandom % 8 == 0) score = ($urandom % 12 == 0) ? 16'h0000 : rand_bcd();
      if (score == 16'h0000 && $urandom % 3 == 0) score = rand_bcd();
      rst = ($urandom % 300 == 0);
      step();
    end
    rst = 0; step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
